// File: rtl/adder_pkg.sv
// Shared constants for the carry-select pipelined adder.
package adder_pkg;

  // Operation encodings carried on the op input.
  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  // Default geometry: 32-bit datapath split into 8-bit carry-select blocks.
  localparam int DEF_WIDTH = 32;
  localparam int DEF_BLK   = 8;

endpackage

// File: rtl/csel_block.sv
// One carry-select block: produces the block sum and carry for both
// possible carry-in values so the select chain can pick one later.
module csel_block #(
  parameter int BLK = 8
) (
  input  logic [BLK-1:0] a,
  input  logic [BLK-1:0] b,
  output logic [BLK-1:0] s0,
  output logic [BLK-1:0] s1,
  output logic           c0,
  output logic           c1
);

  // Dual speculative additions: carry-in 0 and carry-in 1.
  always_comb begin
    {c0, s0} = {1'b0, a} + {1'b0, b};
    {c1, s1} = {1'b0, a} + {1'b0, b} + {{BLK{1'b0}}, 1'b1};
  end

endmodule

// File: rtl/adder_csel_pipe.sv
// Two-stage pipelined carry-select adder/subtractor with valid/ready
// handshakes on both sides. Stage 1 registers the per-block speculative
// sums; stage 2 resolves the select chain and registers the result.
module adder_csel_pipe
  import adder_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int BLK   = DEF_BLK
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int NB = WIDTH / BLK;

  // Signed overflow: operands agree in sign but the result does not.
  function automatic logic ovf_detect(input logic a_msb, input logic b_msb,
                                      input logic s_msb);
    return (a_msb == b_msb) && (s_msb != a_msb);
  endfunction

  logic             s1_en;
  logic             s2_en;

  logic [WIDTH-1:0] b_eff;
  logic             cin_eff;
  logic [WIDTH-1:0] blk_s0;
  logic [WIDTH-1:0] blk_s1;
  logic [NB-1:0]    blk_c0;
  logic [NB-1:0]    blk_c1;

  logic             s1_valid_d, s1_valid_q;
  logic [WIDTH-1:0] s1_s0_d,    s1_s0_q;
  logic [WIDTH-1:0] s1_s1_d,    s1_s1_q;
  logic [NB-1:0]    s1_c0_d,    s1_c0_q;
  logic [NB-1:0]    s1_c1_d,    s1_c1_q;
  logic             s1_cin_d,   s1_cin_q;
  logic             s1_amsb_d,  s1_amsb_q;
  logic             s1_bmsb_d,  s1_bmsb_q;

  logic [WIDTH-1:0] res_sum;
  logic             res_cout;

  logic             out_valid_d, out_valid_q;
  logic [WIDTH-1:0] sum_d,       sum_q;
  logic             cout_d,      cout_q;
  logic             ovf_d,       ovf_q;

  // Backpressure: a stage advances when its downstream slot is free or draining.
  always_comb begin
    s2_en = !out_valid_q || out_ready;
    s1_en = !s1_valid_q || s2_en;
  end

  // Subtraction is a + ~b + 1; the +1 rides in as the block-0 carry.
  always_comb begin
    b_eff   = (op == OP_SUB) ? ~b : b;
    cin_eff = (op == OP_SUB) ? 1'b1 : cin;
  end

  for (genvar k = 0; k < NB; k++) begin : g_blk
    csel_block #(.BLK(BLK)) u_blk (
      .a  (a[k*BLK +: BLK]),
      .b  (b_eff[k*BLK +: BLK]),
      .s0 (blk_s0[k*BLK +: BLK]),
      .s1 (blk_s1[k*BLK +: BLK]),
      .c0 (blk_c0[k]),
      .c1 (blk_c1[k])
    );
  end

  // ---- stage 1: capture speculative block results ----
  // Stage-1 next state: load on enable, otherwise hold.
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_s0_d    = s1_s0_q;
    s1_s1_d    = s1_s1_q;
    s1_c0_d    = s1_c0_q;
    s1_c1_d    = s1_c1_q;
    s1_cin_d   = s1_cin_q;
    s1_amsb_d  = s1_amsb_q;
    s1_bmsb_d  = s1_bmsb_q;
    if (s1_en) begin
      s1_valid_d = in_valid;
      s1_s0_d    = blk_s0;
      s1_s1_d    = blk_s1;
      s1_c0_d    = blk_c0;
      s1_c1_d    = blk_c1;
      s1_cin_d   = cin_eff;
      s1_amsb_d  = a[WIDTH-1];
      s1_bmsb_d  = b_eff[WIDTH-1];
    end
  end

  // Stage-1 valid flag; only control state is reset.
  always_ff @(posedge clk) begin
    if (!rst_n) s1_valid_q <= 1'b0;
    else        s1_valid_q <= s1_valid_d;
  end

  // Stage-1 datapath registers.
  always_ff @(posedge clk) begin
    s1_s0_q   <= s1_s0_d;
    s1_s1_q   <= s1_s1_d;
    s1_c0_q   <= s1_c0_d;
    s1_c1_q   <= s1_c1_d;
    s1_cin_q  <= s1_cin_d;
    s1_amsb_q <= s1_amsb_d;
    s1_bmsb_q <= s1_bmsb_d;
  end

  // ---- stage 2: resolve select chain and register result ----
  // Ripple the selected carry through the blocks to pick each block sum.
  always_comb begin
    logic carry;
    carry   = s1_cin_q;
    res_sum = '0;
    for (int k = 0; k < NB; k++) begin
      res_sum[k*BLK +: BLK] = carry ? s1_s1_q[k*BLK +: BLK] : s1_s0_q[k*BLK +: BLK];
      carry                 = carry ? s1_c1_q[k] : s1_c0_q[k];
    end
    res_cout = carry;
  end

  // Stage-2 next state: load on enable, otherwise hold for the stalled consumer.
  always_comb begin
    out_valid_d = out_valid_q;
    sum_d       = sum_q;
    cout_d      = cout_q;
    ovf_d       = ovf_q;
    if (s2_en) begin
      out_valid_d = s1_valid_q;
      sum_d       = res_sum;
      cout_d      = res_cout;
      ovf_d       = ovf_detect(s1_amsb_q, s1_bmsb_q, res_sum[WIDTH-1]);
    end
  end

  // Stage-2 registers; result is cleared on reset so outputs read zero.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      sum_q       <= '0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      sum_q       <= sum_d;
      cout_q      <= cout_d;
      ovf_q       <= ovf_d;
    end
  end

  assign in_ready  = s1_en;
  assign out_valid = out_valid_q;
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;

endmodule

// File: doc/adder_csel_pipe.md
ADDER_CSEL_PIPE -- requirements
Module: adder_csel_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 32: operand and sum width in bits.
REQ-002 SHALL have parameter BLK, default 8: carry-select block width; WIDTH % BLK == 0 and BLK >= 2 are required; NB = WIDTH/BLK.
REQ-003 SHALL have port clk  input  1: single clock, all state on rising edge.
REQ-004 SHALL have port rst_n  input  1: reset, synchronous, active-low.
REQ-005 SHALL have port in_valid  input  1: operand beat present.
REQ-006 SHALL have port in_ready  output  1: block accepts beat this cycle.
REQ-007 SHALL have ports a, b  input  WIDTH: operands.
REQ-008 SHALL have port cin  input  1: carry-in, used in add mode only.
REQ-009 SHALL have port op  input  1: 0 = add (a+b+cin), 1 = subtract (a-b, i.e. a+~b+1; cin ignored).
REQ-010 SHALL have port out_valid  output  1: result beat present.
REQ-011 SHALL have port out_ready  input  1: downstream accepts result.
REQ-012 SHALL have port sum  output  WIDTH: result.
REQ-013 SHALL have port cout  output  1: carry-out of MSB (subtract: 1 = no borrow).
REQ-014 SHALL have port ovf  output  1: two's-complement signed overflow.

Function
REQ-015 SHALL accept a beat when in_valid && in_ready is high at a rising edge; SHALL emit a beat when out_valid && out_ready is high.
REQ-016 Stage 1 SHALL, per block k, compute and register s0_k/c0_k (block sum, carry-in 0) and s1_k/c1_k (carry-in 1), plus effective block-0 carry-in (cin, or 1 for op=1) and operand MSBs.
REQ-017 Stage 2 SHALL resolve the select chain (carry into block k+1 = selected c of block k, block 0 selected by effective carry-in), and register sum, cout, ovf.
REQ-018 Latency SHALL be exactly 2 cycles from acceptance to out_valid with no stall; throughput one beat per cycle.
REQ-019 ovf SHALL equal (a_msb == b_eff_msb) && (sum_msb != a_msb), where b_eff = b (add) or ~b (sub).
REQ-020 Enables: s2_en = !out_valid || out_ready; s1_en = !s1_valid || s2_en; in_ready = s1_en (combinational, no dependence on in_valid).
REQ-021 Stall: while out_valid && !out_ready, sum/cout/ovf SHALL hold stable; at most 2 beats SHALL be held; no beat dropped or duplicated; order preserved.
REQ-022 Simultaneous accept and emit in one cycle SHALL be supported with no bubble.
REQ-023 Results SHALL be bit-exact with WIDTH+1-bit reference addition for all inputs, including all-ones carry propagation through every block.
REQ-024 Stage registers SHALL load only on their enable; bubbles (valid=0) SHALL propagate as valid=0.

Reset
REQ-025 While rst_n is low at a rising edge: s1_valid, out_valid SHALL clear to 0; sum, cout, ovf SHALL clear to 0.
REQ-026 in_ready SHALL read 1 in the first cycle after reset deasserts.
REQ-027 Reset mid-operation SHALL discard all in-flight beats; no stale beat SHALL appear afterward.

Structure
REQ-028 Shared package adder_pkg SHALL hold op encodings (OP_ADD=0, OP_SUB=1) and default WIDTH/BLK constants.
REQ-029 One sub-module csel_block (parameter BLK) SHALL compute the dual sums/carries of one block; instantiated NB times via generate.

Verification (WIDTH=32, BLK=8)
REQ-030 add 0xFFFFFFFF+0x00000001, cin=0, out_ready=1 -> 2 cycles later sum=0x00000000, cout=1, ovf=0.
REQ-031 sub op=1, a=5, b=7 -> sum=0xFFFFFFFE, cout=0, ovf=0; a=7,b=5 -> sum=2, cout=1.
REQ-032 add 0x7FFFFFFF+0x00000001 -> sum=0x80000000, ovf=1, cout=0; add 0x00FFFFFF+0, cin=1 -> 0x01000000.
REQ-033 Stream 4 beats with out_ready=0 -> exactly 2 accepted, in_ready=0 thereafter; raise out_ready -> all 4 emitted in order, back-to-back.
REQ-034 Assert rst_n=0 for 1 cycle with 2 beats in flight -> out_valid=0, sum=0 next cycle; no old beat later emitted.
REQ-035 Random 10k beats with random in_valid/out_ready, op, cin -> scoreboard match, zero mismatches.
